exe_md_stage: RTL and testbench

Parametrised execute stage for the pipelined CPU core. Combines the single-cycle integer ALU with an iterative multiply/divide unit for the RV M-extension, and owns the EX/MEM pipeline register. It sits between ID/EX and MEM. It raises `busy_o` to the hazard unit while a multi-cycle operation is in flight.

---
 rtl/exe_md_stage.sv | 196 +++++++++++++++++++
 tb/tb_exe_md_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/exe_md_stage.sv
// exe_md_stage: execute stage with single-cycle ALU, iterative RV M-extension
// multiply/divide unit and the EX/MEM pipeline register.
// Optional macro EXE_FAST_MUL_EN: MUL* use a single-cycle multiplier instead of
// the shift-add loop; division is iterative in both builds.
// ALU encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA,
//               8 OR, 9 AND, 10 pass operand 2 (LUI); others give 0.
//
// state  | meaning
// IDLE   | ALU ops pass through; MD op accepted and operands latched
// MUL    | shift-add multiply, one multiplier bit per cycle
// DIV    | restoring divide, one quotient bit per cycle
// DONE   | signed result ready, waits for the EX/MEM load enable
module exe_md_stage #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid_i,
  input  logic [4:0]          alu_op_i,
  input  logic                md_req_i,
  input  logic [2:0]          md_op_i,
  input  logic [XLEN-1:0]     rs1_data_i,
  input  logic [XLEN-1:0]     rs2_data_i,
  input  logic [XLEN-1:0]     imm_i,
  input  logic                alu_src_i,
  input  logic [1:0]          forward_rs1_i,
  input  logic [1:0]          forward_rs2_i,
  input  logic [XLEN-1:0]     mem_rd_data_i,
  input  logic [XLEN-1:0]     wb_rd_data_i,
  input  logic [REG_BITS-1:0] rd_addr_i,
  input  logic                reg_wr_i,
  input  logic                exemem_en_i,
  input  logic                flush_i,
  output logic                busy_o,
  output logic [XLEN-1:0]     mem_aluout_o,
  output logic [REG_BITS-1:0] mem_rd_addr_o,
  output logic                mem_reg_wr_o
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d, res_q, res_d;
  logic [2:0]          op_q, op_d;
  logic                sa_q, sa_d, sb_q, sb_d;
  logic [REG_BITS-1:0] rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [XLEN-1:0]     aluout_q, aluout_d;
  logic [REG_BITS-1:0] mrd_q, mrd_d;
  logic                mwr_q, mwr_d;

  logic [XLEN-1:0]     op1, op2f, op2, alu_res, abs_a, abs_b;
  logic                sa_in, sb_in, md_start;
  logic [XLEN:0]       mul_sum, div_shift;
  logic [2*XLEN-1:0]   mul_step, div_step;

  // Sign-correct the raw magnitude result and pick the half the op wants.
  function automatic logic [XLEN-1:0] md_fix(input logic [2*XLEN-1:0] acc,
                                             input logic [2:0] op,
                                             input logic sa, input logic sb);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, r;
    prod = (sa ^ sb) ? -acc : acc;
    quo  = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      3'd0:             r = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: r = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       r = quo;
      default:          r = rem;
    endcase
    return r;
  endfunction

  // Operand forwarding and the single-cycle ALU.
  always_comb begin
    op1 = (forward_rs1_i == 2'd1) ? mem_rd_data_i :
          (forward_rs1_i == 2'd2) ? wb_rd_data_i  : rs1_data_i;
    op2f = (forward_rs2_i == 2'd1) ? mem_rd_data_i :
           (forward_rs2_i == 2'd2) ? wb_rd_data_i  : rs2_data_i;
    op2 = alu_src_i ? imm_i : op2f;
    case (alu_op_i)
      5'd0:    alu_res = op1 + op2;
      5'd1:    alu_res = op1 - op2;
      5'd2:    alu_res = op1 << op2[CW-1:0];
      5'd3:    alu_res = XLEN'($signed(op1) < $signed(op2));
      5'd4:    alu_res = XLEN'(op1 < op2);
      5'd5:    alu_res = op1 ^ op2;
      5'd6:    alu_res = op1 >> op2[CW-1:0];
      5'd7:    alu_res = $signed(op1) >>> op2[CW-1:0];
      5'd8:    alu_res = op1 | op2;
      5'd9:    alu_res = op1 & op2;
      5'd10:   alu_res = op2;
      default: alu_res = '0;
    endcase
  end

  // Operand signs/magnitudes at acceptance and one iteration of mul/div.
  always_comb begin
    sa_in = (md_op_i == 3'd1 || md_op_i == 3'd2 || md_op_i == 3'd4 || md_op_i == 3'd6)
            && op1[XLEN-1];
    sb_in = (md_op_i == 3'd1 || md_op_i == 3'd4 || md_op_i == 3'd6) && op2f[XLEN-1];
    abs_a = sa_in ? -op1  : op1;
    abs_b = sb_in ? -op2f : op2f;
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    if (div_shift >= {1'b0, opb_q})
      div_step = {div_shift[XLEN-1:0] - opb_q, acc_q[XLEN-2:0], 1'b1};
    else
      div_step = {acc_q[2*XLEN-2:0], 1'b0};
  end

  assign md_start = (state_q == S_IDLE) && id_valid_i && md_req_i && !flush_i;
  assign busy_o   = md_start || (state_q == S_MUL) || (state_q == S_DIV);

  // FSM next state, MD datapath and EX/MEM next values.
  always_comb begin
    state_d = state_q; cnt_d = cnt_q; acc_d = acc_q; opb_d = opb_q;
    res_d = res_q; op_d = op_q; sa_d = sa_q; sb_d = sb_q;
    rd_d = rd_q; wr_d = wr_q;
    aluout_d = aluout_q; mrd_d = mrd_q; mwr_d = mwr_q;
    case (state_q)
      S_IDLE: if (md_start) begin
        op_d = md_op_i; sa_d = sa_in; sb_d = sb_in;
        rd_d = rd_addr_i; wr_d = reg_wr_i;
        acc_d = {{XLEN{1'b0}}, abs_a};
        opb_d = abs_b;
        cnt_d = CW'(XLEN - 1);
        if (md_op_i[2]) begin
          if (op2f == '0) begin
            res_d   = md_op_i[1] ? op1 : '1;
            state_d = S_DONE;
          end else if (!md_op_i[0] && op1 == {1'b1, {(XLEN-1){1'b0}}} && op2f == '1) begin
            res_d   = md_op_i[1] ? '0 : op1;
            state_d = S_DONE;
          end else begin
            state_d = S_DIV;
          end
        end else begin
`ifdef EXE_FAST_MUL_EN
          res_d   = md_fix(abs_a * abs_b, md_op_i, sa_in, sb_in);
          state_d = S_DONE;
`else
          state_d = S_MUL;
`endif
        end
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_MUL) ? mul_step : div_step;
        if (cnt_q == '0) begin
          res_d   = md_fix(acc_d, op_q, sa_q, sb_q);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: if (exemem_en_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;

    if (exemem_en_i) begin
      if (flush_i || (state_q != S_DONE && (busy_o || !id_valid_i))) begin
        aluout_d = '0; mrd_d = '0; mwr_d = 1'b0;
      end else if (state_q == S_DONE) begin
        aluout_d = res_q; mrd_d = rd_q; mwr_d = wr_q;
      end else begin
        aluout_d = alu_res; mrd_d = rd_addr_i; mwr_d = reg_wr_i;
      end
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE; cnt_q <= '0; acc_q <= '0; opb_q <= '0;
      res_q <= '0; op_q <= '0; sa_q <= 1'b0; sb_q <= 1'b0;
      rd_q <= '0; wr_q <= 1'b0;
      aluout_q <= '0; mrd_q <= '0; mwr_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; acc_q <= acc_d; opb_q <= opb_d;
      res_q <= res_d; op_q <= op_d; sa_q <= sa_d; sb_q <= sb_d;
      rd_q <= rd_d; wr_q <= wr_d;
      aluout_q <= aluout_d; mrd_q <= mrd_d; mwr_q <= mwr_d;
    end
  end

  assign mem_aluout_o  = aluout_q;
  assign mem_rd_addr_o = mrd_q;
  assign mem_reg_wr_o  = mwr_q;
endmodule

// File: tb/tb_exe_md_stage.sv
// Directed bench for exe_md_stage (XLEN = 32): ALU ops, M-extension ops with
// busy-length checks, hold in DONE, flush and reset mid-division.
module tb_exe_md_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        id_valid = 0, md_req = 0, alu_src = 0, reg_wr = 0, en = 1, flush = 0;
  logic [4:0]  alu_op = 0, rd = 0;
  logic [2:0]  md_op = 0;
  logic [1:0]  fwd1 = 0, fwd2 = 0;
  logic [31:0] rs1 = 0, rs2 = 0, imm = 0, mem_d = 0, wb_d = 0;
  logic        busy, mwr;
  logic [31:0] mout;
  logic [4:0]  mrd;
  int          n_cmp = 0, n_bad = 0;
`ifdef EXE_FAST_MUL_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif

  exe_md_stage #(.XLEN(32), .REG_BITS(5)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .alu_op_i(alu_op),
    .md_req_i(md_req), .md_op_i(md_op), .rs1_data_i(rs1), .rs2_data_i(rs2),
    .imm_i(imm), .alu_src_i(alu_src), .forward_rs1_i(fwd1), .forward_rs2_i(fwd2),
    .mem_rd_data_i(mem_d), .wb_rd_data_i(wb_d), .rd_addr_i(rd), .reg_wr_i(reg_wr),
    .exemem_en_i(en), .flush_i(flush), .busy_o(busy), .mem_aluout_o(mout),
    .mem_rd_addr_o(mrd), .mem_reg_wr_o(mwr));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic alu_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_imm, input logic [1:0] f1,
                         input logic [31:0] exp, input string tag);
    id_valid = 1; md_req = 0; alu_op = op; alu_src = use_imm; fwd1 = f1; fwd2 = 0;
    rs1 = a; mem_d = a; wb_d = a; rs2 = b; imm = b; rd = 5'd3; reg_wr = 1; en = 1;
    #1 chk({tag, "_busy"}, 32'(busy), 0);
    tick();
    chk(tag, mout, exp);
    chk({tag, "_rd"}, 32'(mrd), 3);
    chk({tag, "_wr"}, 32'(mwr), 1);
    id_valid = 0;
  endtask

  task automatic md_run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_busy, input int hold,
                        input string tag);
    int n;
    id_valid = 1; md_req = 1; md_op = op; rs1 = a; rs2 = b; fwd1 = 0; fwd2 = 0;
    alu_src = 0; rd = 5'd9; reg_wr = 1; en = 1;
    #1 chk({tag, "_busy0"}, 32'(busy), 1);
    n = 0;
    while (busy && n < 100) begin
      tick();
      if (n == 0) begin
        id_valid = 0; md_req = 0; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678;
        mem_d = 32'h0BAD_F00D; wb_d = 32'h5555_AAAA; fwd1 = 2'd2; fwd2 = 2'd1;
        if (hold > 0) en = 0;
        #1;
      end
      n++;
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_busy"}, 32'(busy), 0);
      chk({tag, "_hold_wr"}, 32'(mwr), 0);
      tick();
    end
    en = 1;
    #1 chk({tag, "_done_busy"}, 32'(busy), 0);
    tick();
    chk(tag, mout, exp);
    chk({tag, "_rd"}, 32'(mrd), 9);
    chk({tag, "_wr"}, 32'(mwr), 1);
    fwd1 = 0; fwd2 = 0;
  endtask

  // Load a live ALU result, then start a DIV with EX/MEM held.
  task automatic start_div_held();
    alu_run(5'd0, 32'd5, 32'd7, 1'b1, 2'd0, 32'd12, "pre_add");
    id_valid = 1; md_req = 1; md_op = 3'd5; rs1 = 32'd1000; rs2 = 32'd7;
    fwd1 = 0; fwd2 = 0; rd = 5'd9; en = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) begin id_valid = 0; md_req = 0; end
    end
    chk("mid_div_busy", 32'(busy), 1);
    chk("mid_div_held", mout, 32'd12);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_out", mout, 0);
    chk("rst_rd", 32'(mrd), 0);
    chk("rst_wr", 32'(mwr), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 0;
    tick();

    alu_run(5'd0, 32'd5, 32'd7, 1'b1, 2'd0, 32'd12, "add_imm");
    alu_run(5'd1, 32'd100, 32'd30, 1'b0, 2'd1, 32'd70, "sub_fwdmem");
    alu_run(5'd7, 32'h8000_0000, 32'd4, 1'b1, 2'd2, 32'hF800_0000, "sra_fwdwb");
    alu_run(5'd3, 32'hFFFF_FFFF, 32'd1, 1'b1, 2'd0, 32'd1, "slt");

    md_run(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_BUSY, 0, "mul");
    md_run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, MUL_BUSY, 0, "mulh");
    md_run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_BUSY, 0, "mulhu");
    md_run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_BUSY, 0, "mulhsu");
    md_run(3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 0, "divu_by0");
    md_run(3'd7, 32'd100, 32'd0, 32'd100, 1, 0, "remu_by0");
    md_run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
    md_run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0, "rem_ovf");
    md_run(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, "rem_neg");
    md_run(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, "div_neg");
    md_run(3'd5, 32'd100, 32'd7, 32'd14, 33, 5, "divu_hold");

    start_div_held();
    flush = 1; en = 1;
    tick();
    flush = 0;
    chk("flush_wr", 32'(mwr), 0);
    chk("flush_rd", 32'(mrd), 0);
    chk("flush_busy", 32'(busy), 0);
    tick();
    chk("flush_idle", 32'(busy), 0);

    start_div_held();
    rst = 1;
    tick();
    chk("midrst_out", mout, 0);
    chk("midrst_rd", 32'(mrd), 0);
    chk("midrst_wr", 32'(mwr), 0);
    chk("midrst_busy", 32'(busy), 0);
    rst = 0; en = 1;
    tick();
    md_run(3'd7, 32'd100, 32'd7, 32'd2, 33, 0, "remu_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
